interp_sched: RTL

INTERP_SCHED -- requirements
Module: interp_sched

---
 rtl/interp_pkg.sv | 38 +++
 rtl/quadrant_addr_gen.sv | 71 +++++++
 rtl/interp_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the interpolation scheduler:
//   - default geometry constants (source width, quadrant edge, output pixels)
//   - address widths of the source ROM and the result buffer
//   - scheduler state enum
//   - quad_base(): first source address of a quadrant (used once per run)
// -----------------------------------------------------------------------------
package interp_pkg;

   localparam int IMG_W_DEF   = 400;
   localparam int TILE_DEF    = 100;
   localparam int OUT_PIX_DEF = 88804;
   localparam int TIMEOUT_DEF = 4096;

   localparam int SRC_AW = 18;
   localparam int DST_AW = 17;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DRAIN   = 3'd2,
      WAIT_VB = 3'd3,
      SWAP    = 3'd4
   } sched_state_t;

   // Top-left source address of quadrant {row[1:0], col[1:0]}.
   function automatic logic [SRC_AW-1:0] quad_base(input logic [3:0] quad,
                                                    input int img_w,
                                                    input int tile);
      int row0;
      int col0;
      row0 = int'(quad[3:2]) * tile;
      col0 = int'(quad[1:0]) * tile;
      return SRC_AW'(row0 * img_w + col0);
   endfunction

endpackage

// File: rtl/quadrant_addr_gen.sv
// -----------------------------------------------------------------------------
// quadrant_addr_gen
// Walks a TILE x TILE window of a row-major IMG_W-wide image, column fastest.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load base and zero the row/column indices (wins over step)
//   step        advance to the next pixel of the window
//   base        window origin, sampled on start
//   addr        current source address
//   last        current address is the bottom-right pixel of the window
// Only adders are used: +1 within a row, +(IMG_W-TILE+1) at a row wrap.
// -----------------------------------------------------------------------------
module quadrant_addr_gen
   import interp_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int TILE  = TILE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
   input  logic [SRC_AW-1:0] base,
   output logic [SRC_AW-1:0] addr,
   output logic              last
);

   localparam int                CW       = (TILE > 1) ? $clog2(TILE) : 1;
   localparam logic [CW-1:0]     IDX_LAST = CW'(TILE - 1);
   localparam logic [SRC_AW-1:0] ROW_JUMP = SRC_AW'(IMG_W - TILE + 1);

   logic [SRC_AW-1:0] addr_q, addr_d;
   logic [CW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;

   always_comb begin
      addr_d = addr_q;
      row_d  = row_q;
      col_d  = col_q;
      if (start) begin
         addr_d = base;
         row_d  = '0;
         col_d  = '0;
      end else if (step) begin
         if (col_q == IDX_LAST) begin
            col_d  = '0;
            row_d  = row_q + CW'(1);
            addr_d = addr_q + ROW_JUMP;
         end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + SRC_AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         addr_q <= addr_d;
         row_q  <= row_d;
         col_q  <= col_d;
      end
   end

   assign addr = addr_q;
   assign last = (row_q == IDX_LAST) && (col_q == IDX_LAST);

endmodule

// File: rtl/interp_sched.sv
// -----------------------------------------------------------------------------
// interp_sched
// Schedules one quadrant of the source image through the interpolation
// pipeline, counts the pipeline's output pixels into the back buffer, and
// swaps front/back buffers in the next vertical blank.
// Ports:
//   clk            pixel clock
//   reset          asynchronous, active-low
//   cuadrante      quadrant select, [3:2] row, [1:0] column
//   interpolacion  level, high requests processing
//   vsync_start    one-cycle pulse at start of vertical blank
//   pipe_stall     pipeline backpressure
//   dst_valid      pipeline output pixel strobe
//   src_addr       source ROM address
//   src_valid      source read issued this cycle
//   dst_addr       result buffer write address
//   dst_we         result write enable
//   dst_bank       back buffer being written (~bank_sel)
//   bank_sel       front buffer shown by VGA
//   busy           high in any state except IDLE
//   done           one-cycle pulse on buffer swap
//   err            sticky overflow/timeout flag
//   dbg_state      current scheduler state
// Build option: SCHED_TIMEOUT_EN adds a DRAIN watchdog of TIMEOUT cycles.
//
// Source handshake: src_valid is the valid and ~pipe_stall the ready; a read
// is issued exactly on cycles with src_valid high, and while pipe_stall is
// high src_addr holds the next unissued address.
// -----------------------------------------------------------------------------
module interp_sched
   import interp_pkg::*;
#(
   parameter int IMG_W   = IMG_W_DEF,
   parameter int TILE    = TILE_DEF,
   parameter int OUT_PIX = OUT_PIX_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        cuadrante,
   input  logic              interpolacion,
   input  logic              vsync_start,
   input  logic              pipe_stall,
   input  logic              dst_valid,
   output logic [SRC_AW-1:0] src_addr,
   output logic              src_valid,
   output logic [DST_AW-1:0] dst_addr,
   output logic              dst_we,
   output logic              dst_bank,
   output logic              bank_sel,
   output logic              busy,
   output logic              done,
   output logic              err,
   output sched_state_t      dbg_state
);

   if (TILE < 1 || IMG_W < TILE || OUT_PIX < 1 || OUT_PIX >= (1 << DST_AW) ||
       TIMEOUT < 1) begin : g_param_check
      $error("interp_sched: parameter out of range");
   end

   localparam logic [DST_AW-1:0] OUT_FULL = DST_AW'(OUT_PIX);
   localparam logic [DST_AW-1:0] OUT_LAST = DST_AW'(OUT_PIX - 1);

   sched_state_t      state_q, state_d;
   logic              interp_q;
   logic [3:0]        cuad_prev_q;
   logic              pending_q, pending_d;
   logic [DST_AW-1:0] cnt_q, cnt_d;
   logic              bank_q, bank_d;
   logic              err_q, err_d;

   logic              int_rise;
   logic              cuad_chg;
   logic              accept;
   logic              drop;
   logic              start_run;
   logic              src_valid_w;
   logic              timeout_hit;
   logic              gen_start;
   logic              gen_step;
   logic              gen_last;
   logic [SRC_AW-1:0] gen_base;
   logic [SRC_AW-1:0] gen_addr;

   assign int_rise    = interpolacion && !interp_q;
   assign cuad_chg    = (cuadrante != cuad_prev_q);
   assign src_valid_w = (state_q == FETCH) && !pipe_stall;
   // Output pixels are only taken while a run is active and the frame is
   // not yet full; anything else is an overflow.
   assign accept      = dst_valid && ((state_q == FETCH) || (state_q == DRAIN)) &&
                        (cnt_q != OUT_FULL);
   assign drop        = dst_valid && !accept;

   // The quadrant is captured into the generator on the start cycle; SWAP
   // reloads it with zero so the address reads 0 between runs.
   assign gen_start = start_run || (state_q == SWAP);
   assign gen_base  = (state_q == SWAP) ? '0 : quad_base(cuadrante, IMG_W, TILE);
   assign gen_step  = src_valid_w && !gen_last;

   quadrant_addr_gen #(
      .IMG_W (IMG_W),
      .TILE  (TILE)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (reset),
      .start (gen_start),
      .step  (gen_step),
      .base  (gen_base),
      .addr  (gen_addr),
      .last  (gen_last)
   );

`ifdef SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q, wd_d;

   // Counts consecutive DRAIN cycles with no output pixel.
   always_comb begin
      wd_d = '0;
      if ((state_q == DRAIN) && !dst_valid) wd_d = wd_q + WD_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wd_q <= '0;
      else        wd_q <= wd_d;
   end

   assign timeout_hit = (state_q == DRAIN) && !dst_valid &&
                        (wd_q == WD_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      err_d     = err_q;
      start_run = 1'b0;

      case (state_q)
         IDLE: begin
            if (int_rise || (interpolacion && cuad_chg) || pending_q) begin
               state_d   = FETCH;
               start_run = 1'b1;
            end
         end
         FETCH: begin
            if (src_valid_w && gen_last) state_d = DRAIN;
         end
         DRAIN: begin
            // Full frame either already counted or completed this cycle.
            if ((cnt_q == OUT_FULL) || (accept && (cnt_q == OUT_LAST))) begin
               state_d = WAIT_VB;
            end else if (timeout_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         WAIT_VB: begin
            if (vsync_start) begin
               state_d = SWAP;
               bank_d  = ~bank_q;
            end
         end
         SWAP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      if (accept) cnt_d = cnt_q + DST_AW'(1);

      if (start_run) begin
         cnt_d     = '0;
         pending_d = 1'b0;
      end else if ((state_q != IDLE) && cuad_chg) begin
         pending_d = 1'b1;
      end

      if (drop) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         interp_q    <= 1'b0;
         cuad_prev_q <= '0;
         pending_q   <= 1'b0;
         cnt_q       <= '0;
         bank_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         interp_q    <= interpolacion;
         cuad_prev_q <= cuadrante;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         bank_q      <= bank_d;
         err_q       <= err_d;
      end
   end

   assign src_addr  = gen_addr;
   assign src_valid = src_valid_w;
   assign dst_addr  = cnt_q;
   assign dst_we    = accept;
   assign dst_bank  = ~bank_q;
   assign bank_sel  = bank_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == SWAP);
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule
